cdc_handshake_tx: RTL and testbench
===================================

// Module: cdc_handshake_tx
// PURPOSE
//  Source-side end of a 4-phase req/ack bus crossing.
//  - Takes words from a valid/ready stream in its own clock domain.
//  - Presents each word on data_o with a level req_o toward the destination domain.
//  - Completes the transfer via an ack_i that it synchronizes internally.
//  - Used wherever multi-bit ADAT sample/status words must cross into another
//    clock domain, where per-bit flop synchronization is unsafe.
// PARAMETERS
//  DATA_WIDTH      24  width of the transferred word
//  SYNC_STAGES     2   flops in the ack_i synchronizer chain; legal values >= 2
//  TIMEOUT_CYCLES  0   max cycles per handshake before err_timeout_o; 0 = check disabled
// PORTS
//  clk_i          in   1           source-domain clock
//  rst_ni         in   1           asynchronous, active-low reset
//  s_data_i       in   DATA_WIDTH  input word
//  s_valid_i      in   1           input word valid
//  s_ready_o      out  1           block can accept a word this cycle
//  req_o          out  1           request level to destination domain (registered)
//  data_o         out  DATA_WIDTH  word to destination; stable while req_o=1 and until ack drops
//  ack_i          in   1           acknowledge level from destination domain (asynchronous)
//  busy_o         out  1           high in any state other than ST_IDLE, or when pend_valid_q is set
//  err_timeout_o  out  1           sticky: a handshake exceeded TIMEOUT_CYCLES
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - All outputs 0, state ST_IDLE, pend_valid_q 0, sync chain 0.
//   - req_o drops immediately on reset assertion.
//  ack_s = ack_i after the SYNC_STAGES-flop chain. The FSM uses only ack_s, never raw ack_i.
//  FSM transitions:
//   - ST_IDLE -> ST_REQ on accept.
//     - Accept is s_valid_i && s_ready_o.
//     - On accept: data_q <= s_data_i and req_q <= 1.
//     - req_o is high in the cycle after the accepting edge (latency 1).
//   - ST_REQ: hold req_o=1 and data_o.
//     - When ack_s=1: req_q <= 0, go to ST_ACK_WAIT.
//   - ST_ACK_WAIT: req_o=0; data_o unchanged.
//     - When ack_s=0, the handshake is complete. Then:
//       a) if pend_valid_q: data_q <= pend_q, req_q <= 1, pend_valid_q <= 0, go to ST_REQ;
//       b) else if a word is accepted this cycle: load it directly, go to ST_REQ;
//       c) else go to ST_IDLE.
//  Pending buffer (1 entry):
//   - In ST_REQ/ST_ACK_WAIT, an accepted word goes to pend_q and sets pend_valid_q.
//   - A pending word is never overwritten.
//  s_ready_o:
//   - ST_IDLE: equals !ack_s. A new request is never raised while a stale ack is high,
//     e.g. after a source-only reset.
//   - ST_REQ/ST_ACK_WAIT: equals !pend_valid_q.
//   - On the ST_ACK_WAIT completion cycle with case a): equals 1, since the pending slot
//     frees that cycle.
//  Ordering: words leave in acceptance order; none are dropped or duplicated.
//  Throughput: at most one word per full 4-phase round trip, about 2*(SYNC_STAGES+dest sync)+2 cycles.
//  Timeout (TIMEOUT_CYCLES != 0):
//   - A saturating counter clears on every ST_REQ entry and counts cycles in ST_REQ/ST_ACK_WAIT.
//   - When it reaches TIMEOUT_CYCLES, err_timeout_o <= 1.
//   - err_timeout_o is sticky until rst_ni; the FSM keeps waiting and never aborts.
//   - Counter width is $clog2(TIMEOUT_CYCLES+1).
//  Simultaneous events:
//   - Accept and completion in the same cycle: case a) or b) above applies, no bubble.
//   - ack_s rising while in ST_IDLE is ignored; only s_ready_o is affected.
// STRUCTURE
//  - adat_cdc_pkg holds typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_ACK_WAIT} hs_state_t
//    and the shared SYNC_STAGES default.
//  - One sub-module, sync_ff_rstn: parameterized-depth flop chain with async active-low reset,
//    used for ack_s. The same block is reusable by the destination side.
//  - Data path registers data_q and pend_q have no reset dependency beyond clearing to 0.
// TESTING
//  - Single word: s_data_i=24'hABCDEF, valid 1 cycle; model ack echoes req after 3 cycles.
//    Expect req_o high 1 cycle after accept, data_o=ABCDEF until ack_s falls,
//    and busy_o low after completion.
//  - Back-to-back: 3 words 1,2,3 offered continuously.
//    Expect s_ready_o low while the pending slot is full, delivery order 1,2,3,
//    and a new req_o rise in the same cycle ack_s falls observed for words 2 and 3.
//  - Stale ack: hold ack_i=1 out of reset, then offer a word.
//    Expect s_ready_o=0 and req_o=0 until SYNC_STAGES cycles after ack_i drops.
//  - Timeout: TIMEOUT_CYCLES=16, ack_i never asserted.
//    Expect err_timeout_o=1 exactly 16 cycles after req_o rises, and req_o to stay high.
//  - Reset mid-handshake: assert rst_ni low while in ST_REQ.
//    Expect req_o=0, s_ready_o=0 and busy_o=0 asynchronously, and the pending word discarded.
//  - Random ack delays 0..20 over 1000 words: scoreboard shows exact order, no loss,
//    and data_o never changes while req_o or ack_s is high.

Source files
------------

// File: rtl/adat_cdc_pkg.sv
// Shared types and defaults for the ADAT req/ack bus crossing.
package adat_cdc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_ACK_WAIT = 2'd2
  } hs_state_t;

  localparam int unsigned SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/sync_ff_rstn.sv
// Parameterized-depth flop synchronizer with async active-low reset; chain clears to 0.
module sync_ff_rstn #(
  parameter int unsigned STAGES = 2,
  parameter int unsigned WIDTH  = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source side of a 4-phase req/ack crossing: valid/ready in, level req_o + stable data_o out,
// one-entry pending buffer so a word can be staged while the previous handshake completes.
module cdc_handshake_tx
  import adat_cdc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 24,
  parameter int unsigned SYNC_STAGES    = SYNC_STAGES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  output logic                  req_o,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  ack_i,
  output logic                  busy_o,
  output logic                  err_timeout_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  hs_state_t             state_q;
  logic                  req_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] pend_q;
  logic                  pend_valid_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  ack_s;
  logic                  live_s;
  logic                  ready_raw;
  logic                  accept;

  sync_ff_rstn #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_ack_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (ack_i),
    .q_o    (ack_s)
  );

  // Same-depth chain fed with 1: keeps s_ready_o low until ack_s reflects ack_i,
  // so a stale ack held across reset can never be missed.
  sync_ff_rstn #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_live_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (1'b1),
    .q_o    (live_s)
  );

  always_comb begin
    ready_raw = 1'b0;
    case (state_q)
      ST_IDLE:     ready_raw = !ack_s;
      ST_REQ:      ready_raw = !pend_valid_q;
      ST_ACK_WAIT: ready_raw = !pend_valid_q || !ack_s;
      default:     ready_raw = 1'b0;
    endcase
  end

  assign s_ready_o = live_s && ready_raw;
  assign accept    = s_valid_i && s_ready_o;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (TIMEOUT_CYCLES != 0 && state_q != ST_IDLE) begin
      if (cnt_q != CNT_MAX)  cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_LAST) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      req_q        <= 1'b0;
      data_q       <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            data_q  <= s_data_i;
            req_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (accept) begin
            pend_q       <= s_data_i;
            pend_valid_q <= 1'b1;
          end
          if (ack_s) begin
            req_q   <= 1'b0;
            state_q <= ST_ACK_WAIT;
          end
        end
        ST_ACK_WAIT: begin
          if (ack_s) begin
            if (accept) begin
              pend_q       <= s_data_i;
              pend_valid_q <= 1'b1;
            end
          end else if (pend_valid_q) begin
            // Pending word launches; the slot it vacates may refill on this same edge.
            data_q  <= pend_q;
            req_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= ST_REQ;
            if (accept) pend_q       <= s_data_i;
            else        pend_valid_q <= 1'b0;
          end else if (accept) begin
            data_q  <= s_data_i;
            req_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= ST_REQ;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_o         = req_q;
  assign data_o        = data_q;
  assign busy_o        = (state_q != ST_IDLE) || pend_valid_q;
  assign err_timeout_o = err_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx with a delay-programmable ack responder model.
module tb_cdc_handshake_tx;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic [DW-1:0] s_data_i;
  logic          s_valid_i;
  logic          s_ready_o;
  logic          req_o;
  logic [DW-1:0] data_o;
  logic          ack_i;
  logic          busy_o;
  logic          err_timeout_o;

  logic          resp_en, resp_rand, ack_force, ack_model;
  int            resp_dly;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  assign ack_i = resp_en ? ack_model : ack_force;

  cdc_handshake_tx #(.DATA_WIDTH(DW), .SYNC_STAGES(2), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .s_data_i(s_data_i), .s_valid_i(s_valid_i),
    .s_ready_o(s_ready_o), .req_o(req_o), .data_o(data_o), .ack_i(ack_i),
    .busy_o(busy_o), .err_timeout_o(err_timeout_o)
  );

  // Destination model: echoes req_o onto ack after a fixed or random number of cycles.
  initial begin
    int rcnt, rtgt;
    ack_model = 1'b0;
    rcnt = 0;
    rtgt = 0;
    forever begin
      @(negedge clk);
      if (!resp_en) begin
        ack_model = 1'b0;
        rcnt = 0;
      end else if (req_o !== ack_model) begin
        if (rcnt == 0) rtgt = resp_rand ? int'($urandom_range(20, 0)) : resp_dly;
        if (rcnt >= rtgt) begin
          ack_model = req_o;
          rcnt = 0;
        end else rcnt++;
      end else rcnt = 0;
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    #12;
    checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", req_o); end
    checks++; if (s_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", s_ready_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    checks++; if (err_timeout_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_timeout_o); end
    checks++; if (data_o !== 24'h0) begin errors++; $display("FAIL reset_data: got %h want 000000", data_o); end
    @(negedge clk); rst_ni = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (s_ready_o !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", s_ready_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b want 0", busy_o); end
  endtask

  task automatic test_single_word();
    bit moved = 0;
    bit done = 0;
    resp_en = 1; resp_rand = 0; resp_dly = 3;
    @(negedge clk);
    checks++; if (s_ready_o !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", s_ready_o); end
    s_valid_i = 1'b1; s_data_i = 24'hABCDEF;
    @(negedge clk);
    s_valid_i = 1'b0;
    checks++; if (req_o !== 1'b1) begin errors++; $display("FAIL single_req_latency: got %b want 1", req_o); end
    checks++; if (data_o !== 24'hABCDEF) begin errors++; $display("FAIL single_data: got %h want abcdef", data_o); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy_o); end
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if ((req_o || dut.ack_s) && data_o !== 24'hABCDEF) moved = 1;
      if (!busy_o) done = 1;
    end
    checks++; if (!done) begin errors++; $display("FAIL single_complete: busy still %b after 100 cycles, want 0", busy_o); end
    checks++; if (moved) begin errors++; $display("FAIL single_stable: data_o changed during handshake, want abcdef held"); end
    checks++; if (req_o !== 1'b0 || data_o !== 24'hABCDEF) begin errors++; $display("FAIL single_idle: req %b data %h want 0 abcdef", req_o, data_o); end
    checks++; if (err_timeout_o !== 1'b0) begin errors++; $display("FAIL single_err: got %b want 0", err_timeout_o); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] got[$];
    int  idx = 0, cyc = 0, fall_cyc = -100;
    bit  wa = 0;
    logic prev_req, prev_acks;
    resp_en = 1; resp_rand = 0; resp_dly = 3;
    prev_req = req_o; prev_acks = dut.ack_s;
    for (int c = 0; c < 400 && !(got.size() == 3 && !busy_o && idx == 3); c++) begin
      @(negedge clk); cyc++;
      if (prev_acks && !dut.ack_s) fall_cyc = cyc;
      if (req_o && !prev_req) begin
        got.push_back(data_o);
        if (got.size() > 1) begin
          checks++;
          if (cyc - fall_cyc != 1) begin errors++; $display("FAIL b2b_no_bubble: req rise %0d cycles after ack_s fall, want 1", cyc - fall_cyc); end
        end
      end
      prev_req = req_o; prev_acks = dut.ack_s;
      if (wa) idx++;
      s_valid_i = (idx < 3);
      s_data_i  = DW'(idx + 1);
      wa = s_valid_i && s_ready_o;
      if (cyc == 3) begin
        checks++; if (s_ready_o !== 1'b0) begin errors++; $display("FAIL b2b_pend_full_ready: got %b want 0", s_ready_o); end
      end
    end
    s_valid_i = 1'b0;
    checks++; if (got.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d words want 3", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      checks++; if (got[i] !== DW'(i + 1)) begin errors++; $display("FAIL b2b_order[%0d]: got %h want %h", i, got[i], DW'(i + 1)); end
    end
  endtask

  task automatic test_stale_ack();
    resp_en = 0; ack_force = 1'b1;
    @(negedge clk); rst_ni = 1'b0;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    s_valid_i = 1'b1; s_data_i = 24'h5A5A5A;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      checks++; if (s_ready_o !== 1'b0 || req_o !== 1'b0) begin errors++; $display("FAIL stale_hold[%0d]: ready %b req %b want 0 0", c, s_ready_o, req_o); end
    end
    ack_force = 1'b0;
    @(negedge clk);
    checks++; if (s_ready_o !== 1'b0) begin errors++; $display("FAIL stale_sync1: ready %b want 0", s_ready_o); end
    @(negedge clk);
    checks++; if (s_ready_o !== 1'b1 || req_o !== 1'b0) begin errors++; $display("FAIL stale_release: ready %b req %b want 1 0", s_ready_o, req_o); end
    @(negedge clk);
    s_valid_i = 1'b0;
    checks++; if (req_o !== 1'b1 || data_o !== 24'h5A5A5A) begin errors++; $display("FAIL stale_req: req %b data %h want 1 5a5a5a", req_o, data_o); end
    resp_en = 1; resp_dly = 3;
    for (int c = 0; c < 100 && busy_o; c++) @(negedge clk);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL stale_complete: busy %b want 0", busy_o); end
  endtask

  task automatic test_timeout();
    resp_en = 0; ack_force = 1'b0;
    @(negedge clk);
    checks++; if (s_ready_o !== 1'b1) begin errors++; $display("FAIL to_ready: got %b want 1", s_ready_o); end
    s_valid_i = 1'b1; s_data_i = 24'h123456;
    @(negedge clk);
    s_valid_i = 1'b0;
    checks++; if (req_o !== 1'b1 || err_timeout_o !== 1'b0) begin errors++; $display("FAIL to_start: req %b err %b want 1 0", req_o, err_timeout_o); end
    repeat (15) @(negedge clk);
    checks++; if (err_timeout_o !== 1'b0) begin errors++; $display("FAIL to_early: err %b at 15 cycles want 0", err_timeout_o); end
    @(negedge clk);
    checks++; if (err_timeout_o !== 1'b1 || req_o !== 1'b1) begin errors++; $display("FAIL to_fire: err %b req %b at 16 cycles want 1 1", err_timeout_o, req_o); end
    repeat (10) @(negedge clk);
    checks++; if (err_timeout_o !== 1'b1 || req_o !== 1'b1) begin errors++; $display("FAIL to_sticky: err %b req %b want 1 1", err_timeout_o, req_o); end
  endtask

  task automatic test_reset_mid();
    bit rose = 0;
    @(negedge clk);
    checks++; if (s_ready_o !== 1'b1) begin errors++; $display("FAIL mid_pend_ready: got %b want 1", s_ready_o); end
    s_valid_i = 1'b1; s_data_i = 24'h777777;
    @(negedge clk);
    s_valid_i = 1'b0;
    checks++; if (s_ready_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL mid_pend_full: ready %b busy %b want 0 1", s_ready_o, busy_o); end
    #2 rst_ni = 1'b0;
    #1;
    checks++; if (req_o !== 1'b0 || s_ready_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL mid_async: req %b ready %b busy %b want 0 0 0", req_o, s_ready_o, busy_o); end
    checks++; if (err_timeout_o !== 1'b0 || data_o !== 24'h0) begin errors++; $display("FAIL mid_async_clr: err %b data %h want 0 000000", err_timeout_o, data_o); end
    @(negedge clk); rst_ni = 1'b1;
    resp_en = 1; resp_rand = 0; resp_dly = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (req_o) rose = 1;
    end
    checks++; if (rose) begin errors++; $display("FAIL mid_pend_discard: req_o rose after reset, want pending word dropped"); end
    checks++; if (busy_o !== 1'b0 || s_ready_o !== 1'b1) begin errors++; $display("FAIL mid_idle: busy %b ready %b want 0 1", busy_o, s_ready_o); end
  endtask

  task automatic test_random();
    localparam int N = 1000;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] prev_data, want;
    int  sent = 0, rcvd = 0;
    bit  wa = 0, prev_hold = 0;
    logic prev_req;
    resp_en = 1; resp_rand = 1;
    prev_req = req_o; prev_data = data_o;
    for (int c = 0; c < 60000 && rcvd < N; c++) begin
      @(negedge clk);
      if (prev_hold) begin
        checks++;
        if (data_o !== prev_data) begin errors++; $display("FAIL rnd_stable: data_o %h changed from %h while req/ack_s high", data_o, prev_data); end
      end
      if (req_o && !prev_req) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++;
        if (data_o !== want) begin errors++; $display("FAIL rnd_order[%0d]: got %h want %h", rcvd, data_o, want); end
        rcvd++;
      end
      prev_req = req_o; prev_data = data_o; prev_hold = req_o || dut.ack_s;
      if (!s_valid_i || wa) begin
        s_valid_i = (sent < N) && ($urandom_range(1, 0) == 1);
        s_data_i  = DW'($urandom);
      end
      wa = s_valid_i && s_ready_o;
      if (wa) begin exp_q.push_back(s_data_i); sent++; end
    end
    s_valid_i = 1'b0;
    checks++; if (rcvd != N) begin errors++; $display("FAIL rnd_count: received %0d want %0d", rcvd, N); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rnd_leftover: %0d words undelivered want 0", exp_q.size()); end
  endtask

  initial begin
    rst_ni = 1'b0; s_valid_i = 1'b0; s_data_i = '0;
    resp_en = 0; resp_rand = 0; resp_dly = 3; ack_force = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_stale_ack();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
